phase_sequencer: RTL and testbench

- Timing and state stage that sits around the instruction controller.
- Generates the 3-bit phase consumed by the controller and holds the instruction register that supplies opcode.
- Holds the program counter and drives the memory address mux.
- Consumes the controller strobes sel, ld_ir, inc_pc, ld_pc and halt, and applies them on the clock edge.

---
 rtl/phase_sequencer.sv | 134 +++++++++++++
 tb/tb_phase_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Phase/IR/PC stage around the instruction controller. Optional single-step mode is enabled by macro PHASE_SEQ_STEP_EN.
// Latency: strobes take effect on the next rising edge; mem_addr is combinational from sel.
// Backpressure: none; run is the only handshake, and all strobes are level-sampled once per edge.
module phase_sequencer #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              sel,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              halt,
`ifdef PHASE_SEQ_STEP_EN
    input  logic              step_mode,
`endif
    output logic [2:0]        phase,
    output logic [2:0]        opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc_addr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              running,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The phase at which a halt request is honoured; also where the phase is frozen while halted.
    localparam logic [2:0] HALT_PHASE = 3'd4;

    state_t              state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [DWIDTH-1:0]   ir_q, ir_d;
    logic [AWIDTH-1:0]   pc_q, pc_d;
    logic                running_q, running_d;
    logic                halted_q, halted_d;
    logic                step_stop;

    // The edge that leaves phase 7 ends the instruction when single-stepping.
`ifdef PHASE_SEQ_STEP_EN
    always_comb step_stop = step_mode && (phase_q == 3'd7);
`else
    always_comb step_stop = 1'b0;
`endif

    // Next-state, phase, IR and PC computation.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                // Strobes are ignored; phase 0 is presented in the first RUN cycle.
                phase_d = 3'd0;
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ld_ir) begin
                    ir_d = data_in;
                end
                if (ld_pc) begin
                    pc_d = ir_q[AWIDTH-1:0];
                end else if (inc_pc) begin
                    pc_d = pc_q + AWIDTH'(1);
                end
                if (halt && (phase_q == HALT_PHASE)) begin
                    // Strobes above still apply so pc already points past the HALT.
                    state_d = ST_HALTED;
                    phase_d = phase_q;
                end else if (step_stop) begin
                    state_d = ST_IDLE;
                    phase_d = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            ST_HALTED: begin
                // Controller keeps strobing while phase sits at 4; none of it may reach pc/IR.
                phase_d = HALT_PHASE;
                if (run) begin
                    state_d = ST_RUN;
                    phase_d = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 3'd0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALTED);
    end

    // State registers with synchronous reset that overrides any strobes in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 3'd0;
            ir_q      <= '0;
            pc_q      <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    // Output decode; the memory address mux is purely combinational on sel.
    always_comb begin
        phase    = phase_q;
        opcode   = ir_q[DWIDTH-1 -: 3];
        ir_addr  = ir_q[AWIDTH-1:0];
        pc_addr  = pc_q;
        mem_addr = sel ? pc_q : ir_q[AWIDTH-1:0];
        running  = running_q;
        halted   = halted_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: reset, fetch, halt, jump priority, pc wrap, mid-run reset, step mode.
// Inputs are driven just after the falling edge; outputs are checked at the falling edge.
// Expected values are hand-computed constants for each directed step.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, sel, ld_ir, inc_pc, ld_pc, halt;
    logic [7:0] data_in;
    logic [2:0] phase, opcode;
    logic [4:0] ir_addr, pc_addr, mem_addr;
    logic       running, halted;
`ifdef PHASE_SEQ_STEP_EN
    logic       step_mode;
`endif

    int errors = 0;
    int checks = 0;

    phase_sequencer #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .data_in  (data_in),
        .sel      (sel),
        .ld_ir    (ld_ir),
        .inc_pc   (inc_pc),
        .ld_pc    (ld_pc),
        .halt     (halt),
`ifdef PHASE_SEQ_STEP_EN
        .step_mode(step_mode),
`endif
        .phase    (phase),
        .opcode   (opcode),
        .ir_addr  (ir_addr),
        .pc_addr  (pc_addr),
        .mem_addr (mem_addr),
        .running  (running),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".phase"},   32'(phase),   0);
        chk({tag, ".pc"},      32'(pc_addr), 0);
        chk({tag, ".opcode"},  32'(opcode),  0);
        chk({tag, ".ir_addr"}, 32'(ir_addr), 0);
        chk({tag, ".running"}, 32'(running), 0);
        chk({tag, ".halted"},  32'(halted),  0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sel = 1'b0; ld_ir = 1'b0;
        inc_pc = 1'b0; ld_pc = 1'b0; halt = 1'b0; data_in = 8'h00;
`ifdef PHASE_SEQ_STEP_EN
        step_mode = 1'b0;
`endif
        @(negedge clk);
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Idle with run low: nothing moves.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_reset_vals("idle");
        end

        // Start: first RUN cycle shows phase 0.
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("start.running", 32'(running), 1);
        chk("start.phase",   32'(phase),   0);

        // Fetch 8'hA3 at phases 2,3; a halt at phase 2 must be ignored.
        data_in = 8'hA3;
        for (int p = 0; p < 8; p++) begin
            chk("fetch.phase", 32'(phase), 32'(p));
            chk("fetch.running", 32'(running), 1);
            chk("fetch.opcode", 32'(opcode), (p >= 3) ? 32'd5 : 32'd0);
            ld_ir = (p == 2 || p == 3);
            halt  = (p == 2);
            sel   = p[0];
            #1;
            chk("fetch.mem_addr", 32'(mem_addr), sel ? 32'd0 : ((p >= 3) ? 32'd3 : 32'd0));
            tick();
        end
        ld_ir = 1'b0; halt = 1'b0;
        chk("fetch.wrap_phase", 32'(phase),   0);
        chk("fetch.ir_addr",    32'(ir_addr), 3);

        // Reach phase 4 with pc=6.
        inc_pc = 1'b1;
        repeat (6) tick();
        inc_pc = 1'b0;
        chk("pre_halt.pc",    32'(pc_addr), 6);
        chk("pre_halt.phase", 32'(phase),   6);
        repeat (6) tick();
        chk("pre_halt.phase4", 32'(phase),  4);

        // Halt at phase 4 with inc_pc: pc still advances.
        inc_pc = 1'b1; halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt.pc",      32'(pc_addr), 7);
        chk("halt.halted",  32'(halted),  1);
        chk("halt.running", 32'(running), 0);
        chk("halt.phase",   32'(phase),   4);

        // Strobes while halted are ignored.
        ld_ir = 1'b1; data_in = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halted.pc",     32'(pc_addr), 7);
            chk("halted.phase",  32'(phase),   4);
            chk("halted.opcode", 32'(opcode),  5);
        end
        sel = 1'b1; #1;
        chk("mux.pc", 32'(mem_addr), 7);
        sel = 1'b0; #1;
        chk("mux.ir", 32'(mem_addr), 3);

        // Resume.
        inc_pc = 1'b0; ld_ir = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        chk("resume.running", 32'(running), 1);
        chk("resume.halted",  32'(halted),  0);
        chk("resume.phase",   32'(phase),   0);
        chk("resume.pc",      32'(pc_addr), 7);

        // Jump priority: ld_pc beats inc_pc.
        data_in = 8'h5A; ld_ir = 1'b1;
        tick();
        ld_ir = 1'b0;
        chk("jump.ir_addr", 32'(ir_addr), 32'h1A);
        chk("jump.opcode",  32'(opcode),  2);
        ld_pc = 1'b1; inc_pc = 1'b1;
        tick();
        ld_pc = 1'b0; inc_pc = 1'b0;
        chk("jump.pc",    32'(pc_addr), 32'h1A);
        chk("jump.phase", 32'(phase),   2);

        // pc wraps 0x1F -> 0x00.
        inc_pc = 1'b1;
        repeat (5) tick();
        inc_pc = 1'b0;
        chk("wrap.pc_max", 32'(pc_addr), 32'h1F);
        chk("wrap.phase7", 32'(phase),   7);
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("wrap.pc_zero", 32'(pc_addr), 0);
        chk("wrap.phase0",  32'(phase),   0);

        // Reset at phase 5 with ld_pc pending.
        repeat (5) tick();
        chk("midrst.phase5", 32'(phase), 5);
        ld_pc = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ld_pc = 1'b0;
        chk_reset_vals("midrst");
        tick();
        chk_reset_vals("midrst_idle");

`ifdef PHASE_SEQ_STEP_EN
        // Single step: exactly one 8-phase instruction per run pulse.
        step_mode = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        chk("step.running0", 32'(running), 1);
        chk("step.phase0",   32'(phase),   0);
        for (int p = 1; p < 8; p++) begin
            tick();
            chk("step.phase",   32'(phase),   32'(p));
            chk("step.running", 32'(running), 1);
        end
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("step.end_running", 32'(running), 0);
        chk("step.end_phase",   32'(phase),   0);
        chk("step.end_pc",      32'(pc_addr), 1);
        repeat (3) tick();
        chk("step.hold_phase",   32'(phase),   0);
        chk("step.hold_running", 32'(running), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
